simplez_seq: RTL and testbench
==============================

Name: simplez_seq

Overview:
- Parametrised Simplez control unit: an instruction sequencer that replaces the fixed 4-state test sequencer.
- Decodes all 8 opcodes and drives every datapath micro-order: memory, CP, RI, AC, ALU.
- Memory accesses use a ready handshake, so ROM/RAM/peripherals with wait states plug in unchanged.
- Counts retired instructions; sits between the datapath (RI, AC, CP, RA) and the memory bus in the simplez top level.

Parameters:
OPW, 3, opcode field width; opcode = RI[DATAW-1 -: OPW]; values above 7 decode as HALT
ICW, 16, width of retired-instruction counter
DATAW, 12, datapath width; informational only, used for opcode slicing at top level

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous reset, active-high
op  in  OPW  opcode from RI; sampled only in EXEC
z  in  1  AC==0 flag from datapath
mem_rdy  in  1  memory completes current lec/esc access this cycle
step  in  1  single-step pulse; present only with SIMPLEZ_STEP_EN
lec, esc  out  1  memory read / write strobe
era  out  1  load RA from internal address bus
scp, ecp, incp  out  1  CP drive busAi / load CP from busAi / increment CP
sri, eri  out  1  RI drive address field onto busAi / load RI from busD
sac, eac  out  1  AC drive busD / load AC from ALU
alu_op  out  2  0 PASS, 1 ADD, 2 CLR, 3 DEC
stop  out  1  CPU halted
icount  out  ICW  retired instructions

Behaviour:
- Reset: while rst=1, all micro-orders, alu_op, stop and icount are 0 and state=FETCH_A. After rst falls, the first FETCH_A is active on the next cycle.
- Micro-orders are combinational from state, op, z and mem_rdy. Unlisted outputs are 0.
- FETCH_A: scp, era, incp. Next state FETCH_M.
- FETCH_M: lec held. eri=1 only in the cycle mem_rdy=1, which also moves to EXEC. Stays in FETCH_M while mem_rdy=0 (unbounded wait).
- EXEC, decoded from op:
  - ST, LD, ADD: sri, era; next OPER.
  - BR: sri, ecp; next FETCH_A.
  - BZ: if z=1, sri, ecp; if z=0, no micro-orders; next FETCH_A.
  - CLR: eac, alu_op=2; next FETCH_A.
  - DEC: eac, alu_op=3; next FETCH_A.
  - HALT: next HALTED.
- OPER:
  - ST: sac, esc held until mem_rdy.
  - LD: lec held; eac with alu_op=0 in the mem_rdy cycle.
  - ADD: lec held; eac with alu_op=1 in the mem_rdy cycle.
  - Leaves to FETCH_A on mem_rdy=1. op is latched into an internal register in EXEC; the OPER decode uses the latched value.
- HALTED: stop=1, no micro-orders, stays there until rst.
- mem_rdy outside FETCH_M/OPER is ignored.
- icount increments by 1 on leaving EXEC to FETCH_A (BR, BZ, CLR, DEC), on leaving OPER, and on entering HALTED. It saturates at all-ones, with no wrap.
- Cycle count with mem_rdy always 1:
  - ST/LD/ADD: 4 cycles.
  - BR/BZ/CLR/DEC: 3 cycles.
  - Each wait cycle adds 1.
- rst mid-access (lec/esc high) drops strobes in the same cycle; the access is abandoned.
- An unknown or out-of-range state returns to FETCH_A.

Optional Feature:
- SIMPLEZ_STEP_EN defined:
  - Adds input step and state PAUSE.
  - Every retired non-HALT instruction goes to PAUSE instead of FETCH_A.
  - PAUSE outputs only 0s and leaves to FETCH_A on the cycle after step=1 is sampled. A step held high advances one instruction per 4+ cycles, no skipping.
  - A step high during other states is ignored.
- Undefined: no step port; PAUSE is unreachable and not synthesised.

Decomposition:
- Package simplez_pkg: opcode constants ST..HALT (octal 0-7), ALU op codes PASS/ADD/CLR/DEC, and the state encoding FETCH_A, FETCH_M, EXEC, OPER, HALTED, PAUSE.
- One sub-module is natural: simplez_icount, the saturating ICW-bit retire counter with inc/rst.
- Decode stays in the sequencer.

Test Plan:
- Reset then LD (op=1), mem_rdy=1 -> FETCH_A: scp/era/incp; FETCH_M: lec+eri; EXEC: sri+era; OPER: lec+eac, alu_op=0; icount=1 after 4 cycles.
- ST with mem_rdy low 3 cycles in OPER -> sac+esc held 4 cycles, no eac, FETCH_A follows the mem_rdy cycle.
- BZ with z=1 then BZ with z=0 -> first EXEC has sri+ecp, second has no ecp; 3 cycles each; icount=2.
- CLR, DEC, ADD sequence -> alu_op 2, 3, 1 with eac each in the correct cycle; HALT -> stop=1 permanently, icount=4; mem_rdy pulses ignored.
- rst asserted during FETCH_M wait -> all outputs 0 that cycle; FETCH_A resumes one cycle after rst falls; icount=0.
- ICW=2: retire 5 DECs -> icount=3 saturated.
- SIMPLEZ_STEP_EN: with step=0 after CLR, the block holds in PAUSE 10 cycles; a step pulse gives exactly one more fetch.

Source files
------------

// File: rtl/simplez_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simplez_pkg
// Description : Shared opcode, ALU-operation and sequencer-state encodings
//               for the Simplez control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package simplez_pkg;

  // Instruction opcodes (octal 0-7), taken from the top OPW bits of RI.
  typedef enum logic [2:0] {
    OP_ST   = 3'o0,
    OP_LD   = 3'o1,
    OP_ADD  = 3'o2,
    OP_BR   = 3'o3,
    OP_BZ   = 3'o4,
    OP_CLR  = 3'o5,
    OP_DEC  = 3'o6,
    OP_HALT = 3'o7
  } opcode_e;

  // ALU function select driven with eac.
  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_CLR  = 2'd2;
  localparam logic [1:0] ALU_DEC  = 2'd3;

  // Sequencer states. PAUSE is only reachable in single-step builds.
  typedef enum logic [2:0] {
    FETCH_A = 3'd0,
    FETCH_M = 3'd1,
    EXEC    = 3'd2,
    OPER    = 3'd3,
    HALTED  = 3'd4,
    PAUSE   = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/simplez_icount.sv
`default_nettype none
// ============================================================================
// Module      : simplez_icount
// Description : Saturating retired-instruction counter. Counts one per inc
//               pulse and sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module simplez_icount #(
  parameter int ICW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inc,
  output logic [ICW-1:0] count
);

  logic [ICW-1:0] count_q;
  logic [ICW-1:0] count_d;

  // Next count: advance on inc unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {ICW{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/simplez_seq.sv
`default_nettype none
// ============================================================================
// Module      : simplez_seq
// Description : Simplez instruction sequencer. Fetches via CP/RA/RI, decodes
//               the opcode, issues all datapath micro-orders and waits on
//               mem_rdy for every memory access. Counts retired instructions.
//               Optional single-step mode: define SIMPLEZ_STEP_EN to add the
//               step input and the PAUSE state between instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module simplez_seq
  import simplez_pkg::*;
#(
  parameter int OPW   = 3,
  parameter int ICW   = 16,
  parameter int DATAW = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] op,
  input  logic           z,
  input  logic           mem_rdy,
`ifdef SIMPLEZ_STEP_EN
  input  logic           step,
`endif
  output logic           lec,
  output logic           esc,
  output logic           era,
  output logic           scp,
  output logic           ecp,
  output logic           incp,
  output logic           sri,
  output logic           eri,
  output logic           sac,
  output logic           eac,
  output logic [1:0]     alu_op,
  output logic           stop,
  output logic [ICW-1:0] icount
);

  // An opcode field wider than the data word cannot be sliced from RI;
  // such a build treats every instruction as HALT.
  localparam logic c_cfg_ok = (DATAW >= OPW);

  // Where a retired, non-HALT instruction goes next.
`ifdef SIMPLEZ_STEP_EN
  localparam state_e c_retire_state = PAUSE;
`else
  localparam state_e c_retire_state = FETCH_A;
`endif

  state_e         state_q;
  state_e         state_d;
  opcode_e        op_q;
  opcode_e        op_d;
  opcode_e        op_dec;
  logic           op_hi;
  logic           retire;
  logic [ICW-1:0] count;

  // Opcode values above 7 (only possible when OPW > 3) decode as HALT.
  if (OPW > 3) begin : g_op_wide
    assign op_hi = |op[OPW-1:3];
  end else begin : g_op_narrow
    assign op_hi = 1'b0;
  end

  // Opcode decode from the live RI field.
  always_comb begin
    op_dec = opcode_e'(op[2:0]);
    if (op_hi || !c_cfg_ok) begin
      op_dec = OP_HALT;
    end
  end

  // Next-state and micro-order generation; reset forces every output low.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    retire  = 1'b0;
    lec     = 1'b0;
    esc     = 1'b0;
    era     = 1'b0;
    scp     = 1'b0;
    ecp     = 1'b0;
    incp    = 1'b0;
    sri     = 1'b0;
    eri     = 1'b0;
    sac     = 1'b0;
    eac     = 1'b0;
    alu_op  = ALU_PASS;
    stop    = 1'b0;

    case (state_q)
      FETCH_A: begin
        scp     = 1'b1;
        era     = 1'b1;
        incp    = 1'b1;
        state_d = FETCH_M;
      end

      FETCH_M: begin
        lec = 1'b1;
        if (mem_rdy) begin
          eri     = 1'b1;
          state_d = EXEC;
        end
      end

      EXEC: begin
        op_d = op_dec;
        case (op_dec)
          OP_ST, OP_LD, OP_ADD: begin
            sri     = 1'b1;
            era     = 1'b1;
            state_d = OPER;
          end
          OP_BR: begin
            sri     = 1'b1;
            ecp     = 1'b1;
            retire  = 1'b1;
            state_d = c_retire_state;
          end
          OP_BZ: begin
            sri     = z;
            ecp     = z;
            retire  = 1'b1;
            state_d = c_retire_state;
          end
          OP_CLR: begin
            eac     = 1'b1;
            alu_op  = ALU_CLR;
            retire  = 1'b1;
            state_d = c_retire_state;
          end
          OP_DEC: begin
            eac     = 1'b1;
            alu_op  = ALU_DEC;
            retire  = 1'b1;
            state_d = c_retire_state;
          end
          OP_HALT: begin
            retire  = 1'b1;
            state_d = HALTED;
          end
          default: begin
            state_d = FETCH_A;
          end
        endcase
      end

      // Operand access uses the opcode captured in EXEC, not the live RI.
      OPER: begin
        case (op_q)
          OP_ST: begin
            sac = 1'b1;
            esc = 1'b1;
          end
          OP_LD: begin
            lec = 1'b1;
            if (mem_rdy) begin
              eac    = 1'b1;
              alu_op = ALU_PASS;
            end
          end
          OP_ADD: begin
            lec = 1'b1;
            if (mem_rdy) begin
              eac    = 1'b1;
              alu_op = ALU_ADD;
            end
          end
          default: begin
            state_d = FETCH_A;
          end
        endcase
        if (mem_rdy && (op_q == OP_ST || op_q == OP_LD || op_q == OP_ADD)) begin
          retire  = 1'b1;
          state_d = c_retire_state;
        end
      end

      HALTED: begin
        stop = 1'b1;
      end

`ifdef SIMPLEZ_STEP_EN
      PAUSE: begin
        if (step) begin
          state_d = FETCH_A;
        end
      end
`endif

      default: begin
        state_d = FETCH_A;
      end
    endcase

    if (rst) begin
      retire = 1'b0;
      lec    = 1'b0;
      esc    = 1'b0;
      era    = 1'b0;
      scp    = 1'b0;
      ecp    = 1'b0;
      incp   = 1'b0;
      sri    = 1'b0;
      eri    = 1'b0;
      sac    = 1'b0;
      eac    = 1'b0;
      alu_op = ALU_PASS;
      stop   = 1'b0;
    end
  end

  // State and latched-opcode registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_A;
      op_q    <= OP_ST;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  simplez_icount #(
    .ICW (ICW)
  ) u_icount (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .count (count)
  );

  // The count reads as zero for the whole reset cycle, not just after it.
  assign icount = rst ? '0 : count;

endmodule
`default_nettype wire

// File: tb/tb_simplez_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_simplez_seq
// Description : Directed self-checking bench for simplez_seq. Inputs change
//               just after each falling edge; outputs are compared 1 ns later.
//               A second instance with ICW=2 exercises counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simplez_seq;

  localparam logic [2:0] OP_ST   = 3'o0;
  localparam logic [2:0] OP_LD   = 3'o1;
  localparam logic [2:0] OP_ADD  = 3'o2;
  localparam logic [2:0] OP_BR   = 3'o3;
  localparam logic [2:0] OP_BZ   = 3'o4;
  localparam logic [2:0] OP_CLR  = 3'o5;
  localparam logic [2:0] OP_DEC  = 3'o6;
  localparam logic [2:0] OP_HALT = 3'o7;

  // Observed word: {lec,esc,era,scp,ecp,incp,sri,eri,sac,eac,alu_op,stop}
  localparam logic [12:0] B_LEC  = 13'h1000;
  localparam logic [12:0] B_ESC  = 13'h0800;
  localparam logic [12:0] B_ERA  = 13'h0400;
  localparam logic [12:0] B_SCP  = 13'h0200;
  localparam logic [12:0] B_ECP  = 13'h0100;
  localparam logic [12:0] B_INCP = 13'h0080;
  localparam logic [12:0] B_SRI  = 13'h0040;
  localparam logic [12:0] B_ERI  = 13'h0020;
  localparam logic [12:0] B_SAC  = 13'h0010;
  localparam logic [12:0] B_EAC  = 13'h0008;
  localparam logic [12:0] A_ADD  = 13'h0002;
  localparam logic [12:0] A_CLR  = 13'h0004;
  localparam logic [12:0] A_DEC  = 13'h0006;
  localparam logic [12:0] B_STOP = 13'h0001;

  localparam logic [12:0] E_NONE = 13'h0000;
  localparam logic [12:0] E_FA   = B_SCP | B_ERA | B_INCP;
  localparam logic [12:0] E_FM   = B_LEC;
  localparam logic [12:0] E_FMR  = B_LEC | B_ERI;
  localparam logic [12:0] E_XMEM = B_SRI | B_ERA;

  typedef struct {
    logic        rst;
    logic [2:0]  op;
    logic        rdy;
    logic        z;
    logic        step;
    logic [12:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  op = 3'd0;
  logic        z = 1'b0;
  logic        mem_rdy = 1'b0;
  logic        step = 1'b0;

  logic        lec, esc, era, scp, ecp, incp, sri, eri, sac, eac, stop;
  logic [1:0]  alu_op;
  logic [15:0] icount;

  logic        lec2, esc2, era2, scp2, ecp2, incp2, sri2, eri2, sac2, eac2, stop2;
  logic [1:0]  alu_op2;
  logic [1:0]  icount2;

  int n_cmp = 0;
  int n_bad = 0;

  wire [12:0] obs = {lec, esc, era, scp, ecp, incp, sri, eri, sac, eac, alu_op, stop};

  always #5 clk = ~clk;

  simplez_seq #(.OPW(3), .ICW(16), .DATAW(12)) dut (
    .clk(clk), .rst(rst), .op(op), .z(z), .mem_rdy(mem_rdy),
`ifdef SIMPLEZ_STEP_EN
    .step(step),
`endif
    .lec(lec), .esc(esc), .era(era), .scp(scp), .ecp(ecp), .incp(incp),
    .sri(sri), .eri(eri), .sac(sac), .eac(eac), .alu_op(alu_op),
    .stop(stop), .icount(icount)
  );

  simplez_seq #(.OPW(3), .ICW(2), .DATAW(12)) dut2 (
    .clk(clk), .rst(rst), .op(op), .z(z), .mem_rdy(mem_rdy),
`ifdef SIMPLEZ_STEP_EN
    .step(step),
`endif
    .lec(lec2), .esc(esc2), .era(era2), .scp(scp2), .ecp(ecp2), .incp(incp2),
    .sri(sri2), .eri(eri2), .sac(sac2), .eac(eac2), .alu_op(alu_op2),
    .stop(stop2), .icount(icount2)
  );

  // Apply one cycle of inputs and let the combinational outputs settle.
  task automatic drive(input vec_t v);
    @(negedge clk);
    rst     = v.rst;
    op      = v.op;
    mem_rdy = v.rdy;
    z       = v.z;
    step    = v.step;
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic [2:0] o, input logic rd,
                              input logic zz, input logic [12:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = rd; v.z = zz; v.step = 1'b0; v.exp = e;
    return v;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(mk(1'b1, OP_LD, 1'b1, 1'b0, E_NONE));
      n_cmp++;
      if (obs !== E_NONE) begin
        n_bad++;
        $display("FAIL reset_outputs[%0d]: got %h want %h", i, obs, E_NONE);
      end
      n_cmp++;
      if (icount !== 16'd0) begin
        n_bad++;
        $display("FAIL reset_icount[%0d]: got %0d want 0", i, icount);
      end
    end
  endtask

  task automatic test_ld();
    vec_t v[$];
    v.push_back(mk(1'b0, OP_LD, 1'b1, 1'b0, E_FA));
    v.push_back(mk(1'b0, OP_LD, 1'b1, 1'b0, E_FMR));
    v.push_back(mk(1'b0, OP_LD, 1'b1, 1'b0, E_XMEM));
    v.push_back(mk(1'b0, OP_LD, 1'b1, 1'b0, B_LEC | B_EAC));
    foreach (v[i]) begin
      drive(v[i]);
      n_cmp++;
      if (obs !== v[i].exp) begin
        n_bad++;
        $display("FAIL ld[%0d]: got %h want %h", i, obs, v[i].exp);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (icount !== 16'd1) begin
      n_bad++;
      $display("FAIL ld_icount: got %0d want 1", icount);
    end
  endtask

  // ST with a fetch wait and three operand wait states; op on the bus is
  // changed to LD during OPER so the latched opcode must be the one used.
  task automatic test_st_wait();
    vec_t v[$];
    v.push_back(mk(1'b0, OP_ST, 1'b1, 1'b0, E_FA));
    v.push_back(mk(1'b0, OP_ST, 1'b0, 1'b0, E_FM));
    v.push_back(mk(1'b0, OP_ST, 1'b1, 1'b0, E_FMR));
    v.push_back(mk(1'b0, OP_ST, 1'b1, 1'b0, E_XMEM));
    v.push_back(mk(1'b0, OP_LD, 1'b0, 1'b0, B_SAC | B_ESC));
    v.push_back(mk(1'b0, OP_LD, 1'b0, 1'b0, B_SAC | B_ESC));
    v.push_back(mk(1'b0, OP_LD, 1'b0, 1'b0, B_SAC | B_ESC));
    v.push_back(mk(1'b0, OP_LD, 1'b1, 1'b0, B_SAC | B_ESC));
    foreach (v[i]) begin
      drive(v[i]);
      n_cmp++;
      if (obs !== v[i].exp) begin
        n_bad++;
        $display("FAIL st_wait[%0d]: got %h want %h", i, obs, v[i].exp);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (icount !== 16'd2) begin
      n_bad++;
      $display("FAIL st_icount: got %0d want 2", icount);
    end
  endtask

  task automatic test_bz();
    vec_t v[$];
    v.push_back(mk(1'b0, OP_BZ, 1'b1, 1'b1, E_FA));
    v.push_back(mk(1'b0, OP_BZ, 1'b1, 1'b1, E_FMR));
    v.push_back(mk(1'b0, OP_BZ, 1'b1, 1'b1, B_SRI | B_ECP));
    v.push_back(mk(1'b0, OP_BZ, 1'b1, 1'b0, E_FA));
    v.push_back(mk(1'b0, OP_BZ, 1'b1, 1'b0, E_FMR));
    v.push_back(mk(1'b0, OP_BZ, 1'b1, 1'b0, E_NONE));
    foreach (v[i]) begin
      drive(v[i]);
      n_cmp++;
      if (obs !== v[i].exp) begin
        n_bad++;
        $display("FAIL bz[%0d]: got %h want %h", i, obs, v[i].exp);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (icount !== 16'd4) begin
      n_bad++;
      $display("FAIL bz_icount: got %0d want 4", icount);
    end
  endtask

  task automatic test_alu_seq();
    vec_t v[$];
    v.push_back(mk(1'b0, OP_CLR, 1'b1, 1'b0, E_FA));
    v.push_back(mk(1'b0, OP_CLR, 1'b1, 1'b0, E_FMR));
    v.push_back(mk(1'b0, OP_CLR, 1'b1, 1'b0, B_EAC | A_CLR));
    v.push_back(mk(1'b0, OP_DEC, 1'b1, 1'b0, E_FA));
    v.push_back(mk(1'b0, OP_DEC, 1'b1, 1'b0, E_FMR));
    v.push_back(mk(1'b0, OP_DEC, 1'b1, 1'b0, B_EAC | A_DEC));
    v.push_back(mk(1'b0, OP_ADD, 1'b1, 1'b0, E_FA));
    v.push_back(mk(1'b0, OP_ADD, 1'b1, 1'b0, E_FMR));
    v.push_back(mk(1'b0, OP_ADD, 1'b1, 1'b0, E_XMEM));
    v.push_back(mk(1'b0, OP_ADD, 1'b0, 1'b0, B_LEC));
    v.push_back(mk(1'b0, OP_ADD, 1'b1, 1'b0, B_LEC | B_EAC | A_ADD));
    v.push_back(mk(1'b0, OP_BR,  1'b1, 1'b0, E_FA));
    v.push_back(mk(1'b0, OP_BR,  1'b1, 1'b0, E_FMR));
    v.push_back(mk(1'b0, OP_BR,  1'b1, 1'b0, B_SRI | B_ECP));
    foreach (v[i]) begin
      drive(v[i]);
      n_cmp++;
      if (obs !== v[i].exp) begin
        n_bad++;
        $display("FAIL alu_seq[%0d]: got %h want %h", i, obs, v[i].exp);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (icount !== 16'd8) begin
      n_bad++;
      $display("FAIL alu_seq_icount: got %0d want 8", icount);
    end
  endtask

  task automatic test_halt();
    vec_t v[$];
    v.push_back(mk(1'b0, OP_HALT, 1'b1, 1'b0, E_FA));
    v.push_back(mk(1'b0, OP_HALT, 1'b1, 1'b0, E_FMR));
    v.push_back(mk(1'b0, OP_HALT, 1'b1, 1'b0, E_NONE));
    v.push_back(mk(1'b0, OP_LD,   1'b1, 1'b0, B_STOP));
    v.push_back(mk(1'b0, OP_LD,   1'b0, 1'b1, B_STOP));
    v.push_back(mk(1'b0, OP_BR,   1'b1, 1'b1, B_STOP));
    v.push_back(mk(1'b0, OP_ST,   1'b1, 1'b0, B_STOP));
    foreach (v[i]) begin
      drive(v[i]);
      n_cmp++;
      if (obs !== v[i].exp) begin
        n_bad++;
        $display("FAIL halt[%0d]: got %h want %h", i, obs, v[i].exp);
      end
    end
    n_cmp++;
    if (icount !== 16'd9) begin
      n_bad++;
      $display("FAIL halt_icount: got %0d want 9", icount);
    end
  endtask

  task automatic test_rst_mid();
    vec_t v[$];
    v.push_back(mk(1'b1, OP_LD, 1'b0, 1'b0, E_NONE));
    v.push_back(mk(1'b0, OP_LD, 1'b0, 1'b0, E_FA));
    v.push_back(mk(1'b0, OP_LD, 1'b0, 1'b0, E_FM));
    v.push_back(mk(1'b0, OP_LD, 1'b0, 1'b0, E_FM));
    v.push_back(mk(1'b1, OP_LD, 1'b0, 1'b0, E_NONE));
    v.push_back(mk(1'b0, OP_LD, 1'b0, 1'b0, E_FA));
    foreach (v[i]) begin
      drive(v[i]);
      n_cmp++;
      if (obs !== v[i].exp) begin
        n_bad++;
        $display("FAIL rst_mid[%0d]: got %h want %h", i, obs, v[i].exp);
      end
    end
    n_cmp++;
    if (icount !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_mid_icount: got %0d want 0", icount);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] want2;
    drive(mk(1'b1, OP_DEC, 1'b1, 1'b0, E_NONE));
    for (int k = 1; k <= 5; k++) begin
      drive(mk(1'b0, OP_DEC, 1'b1, 1'b0, E_FA));
      drive(mk(1'b0, OP_DEC, 1'b1, 1'b0, E_FMR));
      drive(mk(1'b0, OP_DEC, 1'b1, 1'b0, B_EAC | A_DEC));
      n_cmp++;
      if (obs !== (B_EAC | A_DEC)) begin
        n_bad++;
        $display("FAIL sat_exec[%0d]: got %h want %h", k, obs, B_EAC | A_DEC);
      end
      @(posedge clk); #1;
      want2 = (k >= 3) ? 2'd3 : 2'(k);
      n_cmp++;
      if (icount2 !== want2) begin
        n_bad++;
        $display("FAIL sat_icount2[%0d]: got %0d want %0d", k, icount2, want2);
      end
      n_cmp++;
      if (icount !== 16'(k)) begin
        n_bad++;
        $display("FAIL sat_icount[%0d]: got %0d want %0d", k, icount, k);
      end
    end
  endtask

`ifdef SIMPLEZ_STEP_EN
  task automatic test_step();
    vec_t v[$];
    vec_t s;
    v.push_back(mk(1'b1, OP_CLR, 1'b1, 1'b0, E_NONE));
    v.push_back(mk(1'b0, OP_CLR, 1'b1, 1'b0, E_FA));
    v.push_back(mk(1'b0, OP_CLR, 1'b1, 1'b0, E_FMR));
    v.push_back(mk(1'b0, OP_CLR, 1'b1, 1'b0, B_EAC | A_CLR));
    for (int i = 0; i < 10; i++) v.push_back(mk(1'b0, OP_CLR, 1'b1, 1'b0, E_NONE));
    s = mk(1'b0, OP_CLR, 1'b1, 1'b0, E_NONE);
    s.step = 1'b1;
    v.push_back(s);
    v.push_back(mk(1'b0, OP_CLR, 1'b1, 1'b0, E_FA));
    v.push_back(mk(1'b0, OP_CLR, 1'b1, 1'b0, E_FMR));
    v.push_back(mk(1'b0, OP_CLR, 1'b1, 1'b0, B_EAC | A_CLR));
    for (int i = 0; i < 3; i++) v.push_back(mk(1'b0, OP_CLR, 1'b1, 1'b0, E_NONE));
    foreach (v[i]) begin
      drive(v[i]);
      n_cmp++;
      if (obs !== v[i].exp) begin
        n_bad++;
        $display("FAIL step[%0d]: got %h want %h", i, obs, v[i].exp);
      end
    end
    n_cmp++;
    if (icount !== 16'd2) begin
      n_bad++;
      $display("FAIL step_icount: got %0d want 2", icount);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SIMPLEZ_STEP_EN
    test_step();
`else
    test_ld();
    test_st_wait();
    test_bz();
    test_alu_seq();
    test_halt();
    test_rst_mid();
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
